// File: rtl/bound_flasher_gen_if.sv
// Control and status bundle of the bound flasher.
// master drives the board controls, slave is the flasher core.
interface bound_flasher_gen_if #(
  parameter int WIDTH = 16
);
  logic             flick;
  logic             pause;
  logic             rpt;
  logic [WIDTH-1:0] led;
  logic [2:0]       phase;
  logic             busy;
  logic             done;

  modport master (
    output flick, pause, rpt,
    input  led, phase, busy, done
  );

  modport slave (
    input  flick, pause, rpt,
    output led, phase, busy, done
  );
endinterface

// File: rtl/bound_flasher_gen.sv
// Parametrised bound flasher: six-phase thermometer bounce
// with step prescaler, pause and auto-repeat.
module bound_flasher_gen #(
  parameter int WIDTH    = 16,
  parameter int B1       = 5,
  parameter int B2       = 10,
  parameter int TICK_DIV = 1
) (
  input logic               clk,
  input logic               rst,
  bound_flasher_gen_if.slave bus
);

  localparam int LW = $clog2(WIDTH + 1);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (WIDTH < 4 || WIDTH > 31 || B1 < 1 || B1 >= B2 ||
      B2 >= WIDTH || TICK_DIV < 1) begin : g_bad_param
    $error("bound_flasher_gen: illegal parameters");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP_FULL = 3'd1,
    DN_B1   = 3'd2,
    UP_B2   = 3'd3,
    DN_ZERO = 3'd4,
    UP_B1   = 3'd5,
    DN_END  = 3'd6,
    BAD     = 3'd7
  } phase_e;

  phase_e           st_q, st_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [DW-1:0]    div_q, div_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic          tick;
  logic          up;
  logic [LW-1:0] tgt;

  function automatic logic [WIDTH-1:0] therm(
    input logic [LW-1:0] l
  );
    logic [WIDTH-1:0] t;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = (LW'(i) < l);
    end
    return t;
  endfunction

  assign tick = busy_q & ~bus.pause &
                (div_q == DW'(TICK_DIV - 1));

  always_comb begin
    tgt = '0;
    up  = 1'b0;
    unique case (st_q)
      UP_FULL: begin tgt = LW'(WIDTH); up = 1'b1; end
      DN_B1:   tgt = LW'(B1);
      UP_B2:   begin tgt = LW'(B2); up = 1'b1; end
      UP_B1:   begin tgt = LW'(B1); up = 1'b1; end
      default: tgt = '0;
    endcase
  end

  always_comb begin
    st_d   = st_q;
    lvl_d  = lvl_q;
    div_d  = div_q;
    done_d = 1'b0;

    if (busy_q && !bus.pause) begin
      div_d = tick ? '0 : div_q + DW'(1);
    end

    unique case (st_q)
      IDLE: begin
        lvl_d = '0;
        div_d = '0;
        if (bus.flick) st_d = UP_FULL;
      end
      BAD: begin
        st_d  = IDLE;
        lvl_d = '0;
        div_d = '0;
      end
      default: begin
        if (tick && lvl_q != tgt) begin
          lvl_d = up ? lvl_q + LW'(1) : lvl_q - LW'(1);
        end else if (tick) begin
          // bound reached: turn around in the same edge
          unique case (st_q)
            UP_FULL: begin
              st_d  = DN_B1;
              lvl_d = lvl_q - LW'(1);
            end
            DN_B1: begin
              st_d  = bus.flick ? UP_FULL : UP_B2;
              lvl_d = lvl_q + LW'(1);
            end
            UP_B2: begin
              st_d  = DN_ZERO;
              lvl_d = lvl_q - LW'(1);
            end
            DN_ZERO: begin
              st_d  = bus.flick ? UP_B2 : UP_B1;
              lvl_d = lvl_q + LW'(1);
            end
            UP_B1: begin
              st_d  = DN_END;
              lvl_d = lvl_q - LW'(1);
            end
            default: begin
              if (bus.rpt) begin
                st_d  = UP_FULL;
                lvl_d = lvl_q + LW'(1);
              end else begin
                st_d   = IDLE;
                lvl_d  = '0;
                done_d = 1'b1;
              end
            end
          endcase
        end
      end
    endcase

    busy_d = (st_d != IDLE);
    led_d  = therm(lvl_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      lvl_q  <= '0;
      div_q  <= '0;
      led_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      lvl_q  <= lvl_d;
      div_q  <= div_d;
      led_q  <= led_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.led   = led_q;
  assign bus.phase = st_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_bound_flasher_gen.sv
// Scoreboard bench: unit 0 has TICK_DIV=1, unit 1 has
// TICK_DIV=4; expected outputs are queued per edge.
module tb_bound_flasher_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bound_flasher_gen_if #(.WIDTH(16)) ifa ();
  bound_flasher_gen_if #(.WIDTH(16)) ifb ();

  bound_flasher_gen #(
    .WIDTH(16), .B1(5), .B2(10), .TICK_DIV(1)
  ) u_a (.clk(clk), .rst(rst), .bus(ifa));

  bound_flasher_gen #(
    .WIDTH(16), .B1(5), .B2(10), .TICK_DIV(4)
  ) u_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    int          u;
    logic [15:0] led;
    logic [2:0]  ph;
    logic        b;
    logic        d;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] th(input int l);
    int v;
    v = (1 << l) - 1;
    return v[15:0];
  endfunction

  task automatic cyc(
    input int u, input bit r, input bit f, input bit p,
    input bit rp, input int l, input int ph,
    input bit b, input bit d
  );
    exp_t e;
    rst = r;
    ifa.flick = (u == 0) ? f : 1'b0;
    ifa.pause = (u == 0) ? p : 1'b0;
    ifa.rpt   = (u == 0) ? rp : 1'b0;
    ifb.flick = (u == 1) ? f : 1'b0;
    ifb.pause = (u == 1) ? p : 1'b0;
    ifb.rpt   = (u == 1) ? rp : 1'b0;
    @(posedge clk);
    e.u = u; e.led = th(l); e.ph = 3'(ph);
    e.b = b; e.d = d;
    q.push_back(e);
    #1;
  endtask

  task automatic seg(
    input int ph, input int from, input int to,
    input bit f = 1'b0, input bit r = 1'b0
  );
    int l = from;
    int s = (to >= from) ? 1 : -1;
    bit first = 1'b1;
    while (1) begin
      cyc(0, 0, first ? f : 1'b0, 0,
          first ? r : 1'b0, l, ph, 1, 0);
      first = 1'b0;
      if (l == to) break;
      l += s;
    end
  endtask

  task automatic cb(input bit f, input bit p, input int l);
    cyc(1, 0, f, p, 0, l, 1, 1, 0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [15:0] al;
    logic [2:0]  ap;
    logic        ab, ad;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.u == 0) begin
          al = ifa.led; ap = ifa.phase;
          ab = ifa.busy; ad = ifa.done;
        end else begin
          al = ifb.led; ap = ifb.phase;
          ab = ifb.busy; ad = ifb.done;
        end
        checks++;
        if (al !== e.led || ap !== e.ph ||
            ab !== e.b || ad !== e.d) begin
          errors++;
          $display("FAIL out%0d chk%0d got led=%h ph=%0d busy=%b done=%b want led=%h ph=%0d busy=%b done=%b",
                   e.u, checks, al, ap, ab, ad,
                   e.led, e.ph, e.b, e.d);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    ifa.flick = 0; ifa.pause = 0; ifa.rpt = 0;
    ifb.flick = 0; ifb.pause = 0; ifb.rpt = 0;

    // reset
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);

    // full sequence
    cyc(0, 0, 1, 0, 0, 0, 1, 1, 0);
    seg(1, 1, 16);
    seg(2, 15, 5);
    seg(3, 6, 10);
    seg(4, 9, 0);
    seg(5, 1, 5);
    seg(6, 4, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // kickbacks then repeat
    cyc(0, 0, 1, 0, 0, 0, 1, 1, 0);
    seg(1, 1, 16);
    seg(2, 15, 5);
    seg(1, 6, 16, 1'b1);
    seg(2, 15, 5);
    seg(3, 6, 10);
    seg(4, 9, 0);
    seg(3, 1, 10, 1'b1);
    seg(4, 9, 0);
    seg(5, 1, 5);
    seg(6, 4, 0);
    seg(1, 1, 16, 1'b0, 1'b1);
    seg(2, 15, 5);
    seg(3, 6, 10);
    seg(4, 9, 0);
    seg(5, 1, 5);
    seg(6, 4, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // reset mid-run with flick high
    cyc(0, 0, 1, 0, 0, 0, 1, 1, 0);
    seg(1, 1, 12);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 1, 1, 0);
    seg(1, 1, 2);

    // prescaler and pause
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cb(1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      repeat (3) cb(0, 0, k - 1);
      cb(0, 0, k);
    end
    cb(0, 0, 3);
    cb(0, 0, 3);
    repeat (3) cb(0, 1, 3);
    cb(0, 0, 3);
    cb(0, 0, 4);
    repeat (3) cb(0, 0, 4);
    cb(0, 0, 5);

    // flick with pause from IDLE
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cb(1, 1, 0);
    repeat (4) cb(0, 1, 0);
    repeat (3) cb(0, 0, 0);
    cb(0, 0, 1);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
